axi4_r_drop_sched: RTL and testbench
====================================

Name: axi4_r_drop_sched

Overview:
Schedules drop requests from NUM_REQ RAB miss/protection sources into the single drop port of axi4_r_sender. It arbitrates among requesters with round-robin priority and latches the winning payload into one issue register. It presents the payload to the sender and throttles new grants so that outstanding drops never exceed the sender's drop FIFO capacity. It also reports outstanding-drop status and idleness to the RAB control logic.

Parameters:
NUM_REQ, 4, number of drop requesters (>=2)
AXI_ID_WIDTH, 4, AXI ID width
MAX_OUTSTANDING, 16, max accepted-but-not-retired drops; equals axi4_r_sender drop FIFO depth
CNT_W, $clog2(MAX_OUTSTANDING+1), outstanding counter width (derived)

Ports:
axi4_aclk  in  1  clock
axi4_arstn  in  1  asynchronous active-low reset
enable_i  in  1  when 0, no new grants are issued
req_valid_i  in  NUM_REQ  per-requester drop request
req_ready_o  out  NUM_REQ  per-requester grant; handshake = valid&ready
req_len_i  in  NUM_REQ*8  burst length (AXI len encoding) per requester
req_id_i  in  NUM_REQ*AXI_ID_WIDTH  AXI ID per requester
req_prefetch_i  in  NUM_REQ  prefetch flag per requester
req_hit_i  in  NUM_REQ  hit (multi/prot) flag per requester
drop_o  out  1  drop request to sender
drop_len_o  out  8  latched len
id_o  out  AXI_ID_WIDTH  latched ID
prefetch_o  out  1  latched prefetch flag
hit_o  out  1  latched hit flag
done_i  in  1  sender accepted the drop (sender push, combinational on drop_o)
retire_i  in  1  one-cycle pulse: a dropped burst finished (rlast handshake while dropping)
outstanding_o  out  CNT_W  current outstanding count
idle_o  out  1  state IDLE and outstanding==0
err_o  out  1  sticky: retire_i received with outstanding==0

Behaviour:
- Reset: state=IDLE, RR pointer=0, payload regs=0, outstanding=0, err_o=0. All outputs 0 except idle_o=1.
- FSM states: IDLE and ISSUE.
- IDLE: grant_ok = enable_i & (outstanding_q < MAX_OUTSTANDING). If grant_ok and any req_valid_i:
  - pick the first valid index at or after the RR pointer, wrapping modulo NUM_REQ;
  - assert req_ready_o[winner] combinationally in the same cycle;
  - latch its len/id/prefetch/hit;
  - set RR pointer to (winner+1) mod NUM_REQ;
  - go to ISSUE.
  Otherwise all req_ready_o=0.
- ISSUE: drop_o=1 with the latched payload, held stable; req_ready_o all 0. On done_i: outstanding increments and the FSM returns to IDLE.
- Latency: grant in cycle t, drop_o in t+1, earliest next grant in t+2 if done_i arrives in t+1. Throughput is at most one drop per 2 cycles.
- done_i while drop_o=0 is ignored.
- outstanding_q next = q + inc - dec, with inc = ISSUE&done_i and dec = retire_i&(q!=0).
  - Simultaneous inc and dec leave the count unchanged.
  - retire_i with q==0 sets err_o; the count stays 0.
- A grant is never issued at outstanding_q==MAX_OUTSTANDING. The drop held in ISSUE is already granted and still completes.
- enable_i deasserted during ISSUE: the ISSUE completes normally; no further grants follow.
- Requesters must hold valid and payload until ready. A withdrawn request is not an error; it is simply not granted.
- Reset mid-operation: asynchronous return to reset values; any pending drop is lost. The sender is reset in the same domain.

Decomposition:
- Package axi_rab_drop_pkg holds typedef drop_req_t {prefetch, hit, id[AXI_ID_WIDTH-1:0], len[7:0]} and state enum {IDLE, ISSUE}.
- Sub-module rab_rr_arbiter: NUM_REQ requests, pointer register, one-hot grant, update-on-accept input. It is reusable for the AW/B path.

Test Plan:
- Single request: req0 valid, len=3, id=5, prefetch=1, hit=0 -> ready0 high in cycle t; drop_o=1 with len=3/id=5 in t+1; done_i in t+1 -> outstanding_o=1, idle_o=0; retire_i -> outstanding_o=0, idle_o=1.
- Round-robin: all 4 valid continuously, done_i tied to drop_o -> grant order 0,1,2,3,0, one grant every 2 cycles.
- Throttle: 16 drops issued with no retire -> outstanding_o=16, no ready asserted while valid held; one retire_i -> next grant within 1 cycle, count back to 16.
- Simultaneous: done_i and retire_i in the same cycle at outstanding=7 -> stays 7. retire_i at outstanding=0 -> err_o=1 and stays 1; count stays 0.
- Backpressure/enable: done_i held 0 for 5 cycles -> drop_o and payload stable, no new ready. enable_i=0 during ISSUE -> ISSUE completes, then no grants until enable_i=1.
- Reset in ISSUE with outstanding=3: assert axi4_arstn=0 asynchronously -> drop_o=0, outstanding_o=0, idle_o=1 immediately; RR restarts at req0.

Source files
------------

// File: rtl/axi_rab_drop_pkg.sv
// Shared types for the RAB drop scheduler.
// Holds the drop payload bundle and the scheduler FSM encoding.
package axi_rab_drop_pkg;

   localparam int DROP_ID_W = 4;

   typedef struct packed {
      logic                 prefetch;
      logic                 hit;
      logic [DROP_ID_W-1:0] id;
      logic [7:0]           len;
   } drop_req_t;

   typedef enum logic {
      IDLE,
      ISSUE
   } state_t;

   function automatic drop_req_t pack_req(
      input logic [7:0]           len,
      input logic [DROP_ID_W-1:0] id,
      input logic                 prefetch,
      input logic                 hit
   );
      drop_req_t r;
      r.prefetch = prefetch;
      r.hit      = hit;
      r.id       = id;
      r.len      = len;
      return r;
   endfunction

endpackage

// File: rtl/rab_rr_arbiter.sv
// Round-robin arbiter with one-hot grant.
// Pointer moves past the winner only when the grant is accepted.
module rab_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               accept,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   logic [IDX_W-1:0] ptr_q;
   int               j;

   // Scan from farthest to nearest so the nearest valid
   // request at or after the pointer wins.
   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      j   = 0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         j = (int'(ptr_q) + i) % NUM_REQ;
         if (req[j]) begin
            any = 1'b1;
            idx = IDX_W'(j);
         end
      end
      if (any) begin
         gnt[idx] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (accept && any) begin
         if (int'(idx) == NUM_REQ - 1) begin
            ptr_q <= '0;
         end else begin
            ptr_q <= idx + 1'b1;
         end
      end
   end

endmodule

// File: rtl/axi4_r_drop_sched.sv
// Drop request scheduler feeding the single drop port of axi4_r_sender.
// Round-robin grants, one issue register, outstanding-drop throttle.
module axi4_r_drop_sched
   import axi_rab_drop_pkg::*;
#(
   parameter int NUM_REQ         = 4,
   parameter int AXI_ID_WIDTH    = DROP_ID_W,
   parameter int MAX_OUTSTANDING = 16,
   parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                            axi4_aclk,
   input  logic                            axi4_arstn,
   input  logic                            enable_i,
   input  logic [NUM_REQ-1:0]              req_valid_i,
   output logic [NUM_REQ-1:0]              req_ready_o,
   input  logic [NUM_REQ*8-1:0]            req_len_i,
   input  logic [NUM_REQ*AXI_ID_WIDTH-1:0] req_id_i,
   input  logic [NUM_REQ-1:0]              req_prefetch_i,
   input  logic [NUM_REQ-1:0]              req_hit_i,
   output logic                            drop_o,
   output logic [7:0]                      drop_len_o,
   output logic [AXI_ID_WIDTH-1:0]         id_o,
   output logic                            prefetch_o,
   output logic                            hit_o,
   input  logic                            done_i,
   input  logic                            retire_i,
   output logic [CNT_W-1:0]                outstanding_o,
   output logic                            idle_o,
   output logic                            err_o
);

   localparam int IDX_W = $clog2(NUM_REQ);

   if (AXI_ID_WIDTH != DROP_ID_W) begin : g_id_chk
      $error("AXI_ID_WIDTH must match DROP_ID_W");
   end

   state_t             state_q;
   state_t             state_d;
   drop_req_t          pay_q;
   drop_req_t          pay_d;
   logic [CNT_W-1:0]   cnt_q;
   logic               err_q;
   logic               grant_ok;
   logic               inc;
   logic               dec;
   logic [NUM_REQ-1:0] arb_req;
   logic [NUM_REQ-1:0] gnt;
   logic [IDX_W-1:0]   idx;
   logic               any;

   assign grant_ok = (state_q == IDLE) && enable_i &&
                     (cnt_q < CNT_W'(MAX_OUTSTANDING));
   assign arb_req  = req_valid_i & {NUM_REQ{grant_ok}};

   rab_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .clk    (axi4_aclk),
      .rst_n  (axi4_arstn),
      .req    (arb_req),
      .accept (grant_ok),
      .gnt    (gnt),
      .idx    (idx),
      .any    (any)
   );

   always_comb begin
      pay_d = pack_req(
         req_len_i[idx*8 +: 8],
         req_id_i[idx*AXI_ID_WIDTH +: AXI_ID_WIDTH],
         req_prefetch_i[idx],
         req_hit_i[idx]
      );
   end

   always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
      if (!axi4_arstn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (any) begin
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (done_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready_o = '0;
      drop_o      = 1'b0;
      unique case (state_q)
         IDLE:    req_ready_o = gnt;
         ISSUE:   drop_o      = 1'b1;
         default: drop_o      = 1'b0;
      endcase
   end

   always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
      if (!axi4_arstn) begin
         pay_q <= '0;
      end else if (any) begin
         pay_q <= pay_d;
      end
   end

   // A retire with nothing outstanding is a protocol slip: flag it
   // and keep the count pinned at zero.
   assign inc = (state_q == ISSUE) && done_i;
   assign dec = retire_i && (cnt_q != '0);

   always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
      if (!axi4_arstn) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_q + CNT_W'(inc) - CNT_W'(dec);
         if (retire_i && (cnt_q == '0)) begin
            err_q <= 1'b1;
         end
      end
   end

   assign drop_len_o    = pay_q.len;
   assign id_o          = pay_q.id;
   assign prefetch_o    = pay_q.prefetch;
   assign hit_o         = pay_q.hit;
   assign outstanding_o = cnt_q;
   assign idle_o        = (state_q == IDLE) && (cnt_q == '0);
   assign err_o         = err_q;

endmodule

// File: tb/tb_axi4_r_drop_sched.sv
// Randomized scoreboard bench for axi4_r_drop_sched.
// A queue of granted payloads is checked as the sender accepts drops.
module tb_axi4_r_drop_sched;

   localparam int N  = 4;
   localparam int IW = 4;
   localparam int MX = 16;
   localparam int CW = 5;

   logic            clk;
   logic            rst_n;
   logic            en;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*8-1:0]  req_len;
   logic [N*IW-1:0] req_id;
   logic [N-1:0]    req_pf;
   logic [N-1:0]    req_hit;
   logic            drop;
   logic [7:0]      drop_len;
   logic [IW-1:0]   drop_id;
   logic            drop_pf;
   logic            drop_hit;
   logic            done;
   logic            retire;
   logic [CW-1:0]   outstanding;
   logic            idle;
   logic            err;

   typedef struct {
      logic [7:0]    len;
      logic [IW-1:0] id;
      logic          pf;
      logic          hit;
   } pay_t;

   pay_t sbq[$];
   int   tests;
   int   fails;
   bit   finished;

   bit   m_busy;
   int   m_ptr;
   int   m_cnt;
   bit   m_err;
   int   m_win;
   pay_t m_cur;
   logic [N-1:0] ready_seen;

   axi4_r_drop_sched #(
      .NUM_REQ         (N),
      .AXI_ID_WIDTH    (IW),
      .MAX_OUTSTANDING (MX),
      .CNT_W           (CW)
   ) dut (
      .axi4_aclk      (clk),
      .axi4_arstn     (rst_n),
      .enable_i       (en),
      .req_valid_i    (req_valid),
      .req_ready_o    (req_ready),
      .req_len_i      (req_len),
      .req_id_i       (req_id),
      .req_prefetch_i (req_pf),
      .req_hit_i      (req_hit),
      .drop_o         (drop),
      .drop_len_o     (drop_len),
      .id_o           (drop_id),
      .prefetch_o     (drop_pf),
      .hit_o          (drop_hit),
      .done_i         (done),
      .retire_i       (retire),
      .outstanding_o  (outstanding),
      .idle_o         (idle),
      .err_o          (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic pay_t req_pay(input int i);
      pay_t p;
      p.len = req_len[i*8 +: 8];
      p.id  = req_id[i*IW +: IW];
      p.pf  = req_pf[i];
      p.hit = req_hit[i];
      return p;
   endfunction

   task automatic set_req(input int i, input int len, input int id,
                          input bit pf, input bit hit);
      req_valid[i]         = 1'b1;
      req_len[i*8 +: 8]    = 8'(len);
      req_id[i*IW +: IW]   = IW'(id);
      req_pf[i]            = pf;
      req_hit[i]           = hit;
   endtask

   task automatic rand_req(input int i);
      set_req(i, $urandom_range(0, 255), $urandom_range(0, 15),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
   endtask

   task automatic model_reset();
      m_busy = 1'b0;
      m_ptr  = 0;
      m_cnt  = 0;
      m_err  = 1'b0;
      m_win  = -1;
      sbq.delete();
   endtask

   // Called #1 after a rising edge with this cycle's inputs applied.
   task automatic step();
      int   j;
      int   old;
      bit   inc;
      bit   dec;
      logic [N-1:0] exp_ready;
      m_win = -1;
      if (!m_busy && en && m_cnt < MX) begin
         for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (req_valid[j] && m_win < 0) m_win = j;
         end
      end
      exp_ready = '0;
      if (m_win >= 0) begin
         exp_ready[m_win] = 1'b1;
         sbq.push_back(req_pay(m_win));
      end
      @(negedge clk);
      ready_seen = req_ready;
      chk("ready", int'(req_ready), int'(exp_ready));
      chk("drop", int'(drop), int'(m_busy));
      chk("outstanding", int'(outstanding), m_cnt);
      chk("idle", int'(idle), int'(!m_busy && m_cnt == 0));
      chk("err", int'(err), int'(m_err));
      if (m_busy) begin
         chk("hold_len", int'(drop_len), int'(m_cur.len));
         chk("hold_id", int'(drop_id), int'(m_cur.id));
      end
      @(posedge clk);
      #1;
      old = m_cnt;
      inc = m_busy && done;
      dec = retire && old != 0;
      if (retire && old == 0) m_err = 1'b1;
      m_cnt = old + int'(inc) - int'(dec);
      if (m_busy) begin
         if (done) m_busy = 1'b0;
      end else if (m_win >= 0) begin
         m_busy = 1'b1;
         m_ptr  = (m_win + 1) % N;
         m_cur  = req_pay(m_win);
         req_valid[m_win] = 1'b0;
      end
   endtask

   task automatic drain();
      int n;
      req_valid = '0;
      retire    = 1'b0;
      n = 0;
      while (m_busy && n < 20) begin
         done = 1'b1;
         step();
         n++;
      end
      done = 1'b0;
      n = 0;
      while (m_cnt > 0 && n < 40) begin
         retire = 1'b1;
         step();
         n++;
      end
      retire = 1'b0;
   endtask

   task automatic run();
      int   g;
      logic [7:0] cap_len;
      int   rr;

      rst_n = 1'b0; en = 1'b1; done = 1'b0; retire = 1'b0;
      req_valid = '0; req_len = '0; req_id = '0;
      req_pf = '0; req_hit = '0;
      model_reset();
      #13;
      chk("rst_ready", int'(req_ready), 0);
      chk("rst_drop", int'(drop), 0);
      chk("rst_len", int'(drop_len), 0);
      chk("rst_cnt", int'(outstanding), 0);
      chk("rst_idle", int'(idle), 1);
      chk("rst_err", int'(err), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // round-robin with all requesters valid
      g = 0;
      for (int c = 0; c < 10; c++) begin
         for (int i = 0; i < N; i++) if (!req_valid[i]) rand_req(i);
         done = drop;
         step();
         if (ready_seen != '0) begin
            chk("rr_order", int'(ready_seen), 1 << (g % N));
            g++;
         end
      end
      chk("rr_grants", g, 5);
      drain();

      // single request
      set_req(0, 3, 5, 1'b1, 1'b0);
      step();
      chk("single_ready", int'(ready_seen), 1);
      done = 1'b1;
      step();
      done = 1'b0;
      chk("single_len", int'(drop_len), 3);
      step();
      chk("single_cnt", int'(outstanding), 1);
      chk("single_idle", int'(idle), 0);
      retire = 1'b1;
      step();
      retire = 1'b0;
      step();
      chk("single_ret", int'(outstanding), 0);
      chk("single_idle1", int'(idle), 1);

      // throttle at full drop FIFO
      for (int c = 0; c < 40; c++) begin
         for (int i = 0; i < N; i++) if (!req_valid[i]) rand_req(i);
         done = drop;
         step();
      end
      chk("thr_full", int'(outstanding), MX);
      chk("thr_noready", int'(ready_seen), 0);
      done = 1'b0;
      retire = 1'b1;
      step();
      retire = 1'b0;
      step();
      chk("thr_regrant", int'(ready_seen != '0), 1);
      done = 1'b1;
      step();
      done = 1'b0;
      step();
      chk("thr_refull", int'(outstanding), MX);

      // simultaneous inc/dec and retire underflow
      req_valid = '0;
      while (m_cnt > 7) begin
         retire = 1'b1;
         step();
      end
      retire = 1'b0;
      set_req(2, 9, 2, 1'b0, 1'b1);
      step();
      done = 1'b1;
      retire = 1'b1;
      step();
      done = 1'b0;
      retire = 1'b0;
      chk("simul_cnt", int'(outstanding), 7);
      drain();
      retire = 1'b1;
      step();
      retire = 1'b0;
      step();
      chk("underflow_err", int'(err), 1);
      chk("underflow_cnt", int'(outstanding), 0);

      // backpressure on done
      set_req(1, 77, 6, 1'b1, 1'b1);
      set_req(3, 12, 9, 1'b0, 1'b0);
      step();
      cap_len = drop_len;
      for (int c = 0; c < 5; c++) begin
         step();
         chk("bp_drop", int'(drop), 1);
         chk("bp_len", int'(drop_len), int'(cap_len));
      end
      done = 1'b1;
      step();
      done = 1'b0;

      // enable dropped during ISSUE
      step();
      en = 1'b0;
      done = 1'b1;
      step();
      done = 1'b0;
      set_req(0, 1, 1, 1'b0, 1'b0);
      for (int c = 0; c < 4; c++) begin
         step();
         chk("en_noready", int'(ready_seen), 0);
      end
      en = 1'b1;
      step();
      chk("en_regrant", int'(ready_seen != '0), 1);
      drain();

      // randomized traffic
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && $urandom_range(0, 99) < 40) rand_req(i);
            else if (req_valid[i] && $urandom_range(0, 99) < 4) req_valid[i] = 1'b0;
         end
         rr = (c < 200) ? 8 : (c < 400) ? 60 : 35;
         done   = 1'($urandom_range(0, 1));
         retire = ($urandom_range(0, 99) < rr);
         en     = ($urandom_range(0, 99) < 90);
         step();
      end
      en = 1'b1;
      drain();

      // reset while a drop is in ISSUE with three outstanding
      for (int c = 0; c < 3; c++) begin
         set_req(c, c + 20, c, 1'b0, 1'b0);
         step();
         done = 1'b1;
         step();
         done = 1'b0;
      end
      set_req(3, 44, 4, 1'b1, 1'b0);
      step();
      chk("pre_rst_cnt", int'(outstanding), 3);
      chk("pre_rst_drop", int'(drop), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_drop", int'(drop), 0);
      chk("arst_cnt", int'(outstanding), 0);
      chk("arst_idle", int'(idle), 1);
      chk("arst_err", int'(err), 0);
      model_reset();
      req_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) rand_req(i);
      step();
      chk("arst_rr0", int'(ready_seen), 1);
      done = 1'b1;
      step();
      done = 1'b0;
   endtask

   initial begin
      tests    = 0;
      fails    = 0;
      finished = 1'b0;
      fork
         begin
            run();
            finished = 1'b1;
         end
         begin
            pay_t e;
            while (!finished) begin
               @(negedge clk);
               if (rst_n && drop && done) begin
                  chk("sb_nonempty", int'(sbq.size() != 0), 1);
                  if (sbq.size() != 0) begin
                     e = sbq.pop_front();
                     chk("sb_len", int'(drop_len), int'(e.len));
                     chk("sb_id", int'(drop_id), int'(e.id));
                     chk("sb_pf", int'(drop_pf), int'(e.pf));
                     chk("sb_hit", int'(drop_hit), int'(e.hit));
                  end
               end
            end
         end
      join
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

endmodule
